seven_segment_scan_decoder: RTL and testbench

- Receive-side counterpart of the 8-digit multiplexed seven-segment scan bus (seg_a..seg_g, seg_dp, digit_selects).
- Samples the scan bus and rejects switching glitches with a dwell filter, then de-multiplexes the digits.
- Decodes each segment pattern back to suffix, note and octave codes and presents a complete frame with a valid pulse.
- Used for display loopback checking on-chip and as the scoreboard front-end in system benches.

---
 rtl/seven_segment_scan_decoder.sv | 205 ++++++++++++++++++++
 tb/tb_seven_segment_scan_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_decoder.sv
// Receive-side decoder for the 8-digit multiplexed seven-segment scan bus: dwell filter, demux, pattern decode, frame assembly.
// Build option SEG_SCAN_ACTIVE_LOW_EN: invert all scan inputs for common-anode boards with active-low selects.
module seven_segment_scan_decoder #(
  parameter int STABLE_CYCLES = 16,
  parameter int FRAME_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       seg_a,
  input  logic       seg_b,
  input  logic       seg_c,
  input  logic       seg_d,
  input  logic       seg_e,
  input  logic       seg_f,
  input  logic       seg_g,
  input  logic       seg_dp,
  input  logic [7:0] digit_selects,
  input  logic       err_clr,
  output logic [1:0] suffix_code,
  output logic [2:0] note_seg1,
  output logic [2:0] note_seg2,
  output logic [2:0] note_seg3,
  output logic [2:0] note_seg4,
  output logic [2:0] note_seg5,
  output logic [2:0] note_seg6,
  output logic [1:0] octave_state,
  output logic       frame_valid,
  output logic       pattern_error,
  output logic       select_error,
  output logic       scan_timeout
);

  localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [CW-1:0] DWELL_ARM = CW'(STABLE_CYCLES - 2);
  localparam logic [CW-1:0] DWELL_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_MAX    = TW'(FRAME_TIMEOUT);

  // Decoders return {unrecognised, code}; segment vector is {g,f,e,d,c,b,a}.
  function automatic logic [2:0] dec_suffix(input logic [6:0] p);
    case (p)
      7'b0000000: dec_suffix = 3'b0_00;
      7'b1110110: dec_suffix = 3'b0_01;
      7'b1111100: dec_suffix = 3'b0_10;
      7'b1100011: dec_suffix = 3'b0_11;
      default:    dec_suffix = 3'b1_00;
    endcase
  endfunction

  function automatic logic [3:0] dec_note(input logic [6:0] p);
    case (p)
      7'b0000000: dec_note = 4'b0_000;
      7'b0000110: dec_note = 4'b0_001;
      7'b1011011: dec_note = 4'b0_010;
      7'b1001111: dec_note = 4'b0_011;
      7'b1100110: dec_note = 4'b0_100;
      7'b1101101: dec_note = 4'b0_101;
      7'b1111101: dec_note = 4'b0_110;
      7'b0000111: dec_note = 4'b0_111;
      default:    dec_note = 4'b1_000;
    endcase
  endfunction

  function automatic logic [2:0] dec_octave(input logic [6:0] p);
    case (p)
      7'b1000000: dec_octave = 3'b0_00;
      7'b0000001: dec_octave = 3'b0_01;
      7'b0001000: dec_octave = 3'b0_10;
      default:    dec_octave = 3'b1_11;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [7:0] s);
    is_onehot = (s != 8'd0) && ((s & (s - 8'd1)) == 8'd0);
  endfunction

  logic [15:0]   raw_s;
  logic [15:0]   sync1_r, sync2_r;
  logic [14:0]   prev_r;
  logic [7:0]    sel_s;
  logic [6:0]    seg_s;
  logic          unused_dp_s;
  logic [CW-1:0] dwell_r, dwell_n_s;
  logic [TW-1:0] to_r, to_n_s;
  logic          same_s, arm_s, cap_s, sel_err_s, pat_err_s, ready_s;
  logic [2:0]    suf_d_s, oct_d_s;
  logic [3:0]    note_d_s;
  logic [7:0]    seen_r, seen_n_s;
  logic [1:0]    suffix_sh_r, oct_sh_r;
  logic [2:0]    note_sh_r [6];

`ifdef SEG_SCAN_ACTIVE_LOW_EN
  assign raw_s = ~{digit_selects, seg_dp, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
`else
  assign raw_s = {digit_selects, seg_dp, seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a};
`endif

  assign sel_s       = sync2_r[15:8];
  assign seg_s       = sync2_r[6:0];
  assign unused_dp_s = sync2_r[7];

  assign same_s    = ({sel_s, seg_s} == prev_r);
  assign arm_s     = same_s && (dwell_r == DWELL_ARM);
  assign cap_s     = arm_s && is_onehot(sel_s);
  assign sel_err_s = arm_s && (sel_s != 8'd0) && !is_onehot(sel_s);
  assign ready_s   = (seen_r == 8'hFF);
  assign suf_d_s   = dec_suffix(seg_s);
  assign note_d_s  = dec_note(seg_s);
  assign oct_d_s   = dec_octave(seg_s);

  // Next-state for dwell and timeout counters, seen mask and pattern-error event.
  always_comb begin
    dwell_n_s = dwell_r;
    to_n_s    = to_r;
    seen_n_s  = seen_r;
    pat_err_s = 1'b0;
    if (!same_s) dwell_n_s = '0;
    else if (dwell_r == DWELL_MAX) dwell_n_s = DWELL_MAX;
    else dwell_n_s = dwell_r + CW'(1);

    if (cap_s) to_n_s = '0;
    else if (to_r == TO_MAX) to_n_s = TO_MAX;
    else to_n_s = to_r + TW'(1);

    // A frame being published this cycle releases its seen bits first.
    if (ready_s) seen_n_s = 8'h00;
    else seen_n_s = seen_r;
    if (cap_s) seen_n_s = seen_n_s | sel_s;
    else if (to_n_s == TO_MAX) seen_n_s = 8'h00;
    else seen_n_s = seen_n_s;

    if (!cap_s) pat_err_s = 1'b0;
    else if (sel_s[0]) pat_err_s = suf_d_s[2];
    else if (sel_s[7]) pat_err_s = oct_d_s[2];
    else pat_err_s = note_d_s[3];
  end

  // Two-flop synchronizer, dwell history and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 16'd0;
      sync2_r <= 16'd0;
      prev_r  <= 15'd0;
      dwell_r <= '0;
      to_r    <= '0;
      seen_r  <= 8'd0;
    end else begin
      sync1_r <= raw_s;
      sync2_r <= sync1_r;
      prev_r  <= {sel_s, seg_s};
      dwell_r <= dwell_n_s;
      to_r    <= to_n_s;
      seen_r  <= seen_n_s;
    end
  end

  // Shadow slot storage written on each capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suffix_sh_r <= 2'b00;
      oct_sh_r    <= 2'b00;
      for (int k = 0; k < 6; k++) note_sh_r[k] <= 3'd0;
    end else if (cap_s) begin
      if (sel_s[0]) suffix_sh_r <= suf_d_s[1:0];
      if (sel_s[7]) oct_sh_r <= oct_d_s[1:0];
      for (int k = 1; k <= 6; k++) begin
        if (sel_s[k]) note_sh_r[k-1] <= note_d_s[2:0];
      end
    end
  end

  // Published frame, valid pulse, sticky error flags and timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      suffix_code   <= 2'b00;
      note_seg1     <= 3'd0;
      note_seg2     <= 3'd0;
      note_seg3     <= 3'd0;
      note_seg4     <= 3'd0;
      note_seg5     <= 3'd0;
      note_seg6     <= 3'd0;
      octave_state  <= 2'b00;
      frame_valid   <= 1'b0;
      pattern_error <= 1'b0;
      select_error  <= 1'b0;
      scan_timeout  <= 1'b0;
    end else begin
      frame_valid   <= ready_s;
      pattern_error <= pat_err_s || (pattern_error && !err_clr);
      select_error  <= sel_err_s || (select_error && !err_clr);
      scan_timeout  <= (to_n_s == TO_MAX);
      if (ready_s) begin
        suffix_code  <= suffix_sh_r;
        note_seg1    <= note_sh_r[0];
        note_seg2    <= note_sh_r[1];
        note_seg3    <= note_sh_r[2];
        note_seg4    <= note_sh_r[3];
        note_seg5    <= note_sh_r[4];
        note_seg6    <= note_sh_r[5];
        octave_state <= oct_sh_r;
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
// Table-driven bench for seven_segment_scan_decoder (STABLE_CYCLES=4, FRAME_TIMEOUT=200), default active-high build.
module tb_seven_segment_scan_decoder;

  logic clk = 1'b0;
  logic rst_n, seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp, err_clr;
  logic [7:0] digit_selects;
  logic [1:0] suffix_code, octave_state;
  logic [2:0] note_seg1, note_seg2, note_seg3, note_seg4, note_seg5, note_seg6;
  logic frame_valid, pattern_error, select_error, scan_timeout;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fv_cnt = 0;

  always #5 clk = ~clk;

  seven_segment_scan_decoder #(.STABLE_CYCLES(4), .FRAME_TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n),
    .seg_a(seg_a), .seg_b(seg_b), .seg_c(seg_c), .seg_d(seg_d),
    .seg_e(seg_e), .seg_f(seg_f), .seg_g(seg_g), .seg_dp(seg_dp),
    .digit_selects(digit_selects), .err_clr(err_clr),
    .suffix_code(suffix_code),
    .note_seg1(note_seg1), .note_seg2(note_seg2), .note_seg3(note_seg3),
    .note_seg4(note_seg4), .note_seg5(note_seg5), .note_seg6(note_seg6),
    .octave_state(octave_state), .frame_valid(frame_valid),
    .pattern_error(pattern_error), .select_error(select_error),
    .scan_timeout(scan_timeout)
  );

  typedef struct {
    logic [7:0][6:0] pat;
    logic            clr;
    logic            glitch;
    logic [1:0]      suf;
    logic [17:0]     notes;
    logic [1:0]      oct;
    logic            perr;
  } frame_t;

  localparam logic [6:0] BL = 7'b0000000, N1 = 7'b0000110, N2 = 7'b1011011,
                         N3 = 7'b1001111, N4 = 7'b1100110, N5 = 7'b1101101,
                         N6 = 7'b1111101, N7 = 7'b0000111;

  function automatic frame_t mkf(input logic [6:0] p0, p1, p2, p3, p4, p5, p6, p7,
                                 input logic clr, glitch, input logic [1:0] suf,
                                 input logic [17:0] notes, input logic [1:0] oct,
                                 input logic perr);
    frame_t f;
    f.pat[0] = p0; f.pat[1] = p1; f.pat[2] = p2; f.pat[3] = p3;
    f.pat[4] = p4; f.pat[5] = p5; f.pat[6] = p6; f.pat[7] = p7;
    f.clr = clr; f.glitch = glitch; f.suf = suf; f.notes = notes; f.oct = oct; f.perr = perr;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (frame_valid === 1'b1) fv_cnt++;
  endtask

  task automatic drive(input logic [7:0] sel, input logic [6:0] seg);
    digit_selects = sel;
    {seg_g, seg_f, seg_e, seg_d, seg_c, seg_b, seg_a} = seg;
    seg_dp = sel[0];
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic scan_slot(input int k, input logic [6:0] seg, input int n);
    drive(8'b1 << k, seg);
    repeat (n) tick();
  endtask

  task automatic scan_frame(input frame_t f);
    fv_cnt = 0;
    if (f.clr) pulse_clr();
    for (int k = 0; k < 8; k++) begin
      scan_slot(k, f.pat[k], 10);
      if (f.glitch && k < 7) begin
        drive(8'h03, 7'($urandom));
        repeat (3) tick();
      end
    end
    drive(8'h00, BL);
    repeat (6) tick();
  endtask

  task automatic check_frame(input string tag, input frame_t f);
    chk({tag, " frame_valid pulses"}, fv_cnt, 1);
    chk({tag, " suffix_code"}, suffix_code, f.suf);
    chk({tag, " notes"}, {note_seg1, note_seg2, note_seg3, note_seg4, note_seg5, note_seg6}, f.notes);
    chk({tag, " octave_state"}, octave_state, f.oct);
    chk({tag, " pattern_error"}, pattern_error, f.perr);
    chk({tag, " select_error"}, select_error, 1'b0);
  endtask

  initial begin
    frame_t vec [6];
    int fv_tick;

    vec[0] = mkf(7'b1110110, N1, N2, N3, N4, N5, N6, 7'b0000001, 1'b0, 1'b0,
                 2'b01, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 2'b01, 1'b0);
    vec[1] = mkf(7'b1110110, N1, N2, N3, N4, N5, N6, 7'b0000001, 1'b0, 1'b1,
                 2'b01, {3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 2'b01, 1'b0);
    vec[2] = mkf(7'b1111100, N7, BL, N6, N5, N4, N3, 7'b1000000, 1'b0, 1'b0,
                 2'b10, {3'd7, 3'd0, 3'd6, 3'd5, 3'd4, 3'd3}, 2'b00, 1'b0);
    vec[3] = mkf(7'b1100011, N2, N2, N2, 7'b1010101, N2, N2, 7'b0001000, 1'b0, 1'b0,
                 2'b11, {3'd2, 3'd2, 3'd2, 3'd0, 3'd2, 3'd2}, 2'b10, 1'b1);
    vec[4] = mkf(7'b0000000, N6, N5, N4, N3, N2, N1, 7'b0000001, 1'b1, 1'b0,
                 2'b00, {3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1}, 2'b01, 1'b0);
    vec[5] = mkf(7'b1010101, N3, N3, N3, N3, N3, N3, 7'b1111111, 1'b1, 1'b0,
                 2'b00, {3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3}, 2'b11, 1'b1);

    rst_n = 1'b0;
    err_clr = 1'b0;
    drive(8'h00, BL);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (2) tick();
    chk("reset outputs", {suffix_code, note_seg1, note_seg2, note_seg3, note_seg4,
                          note_seg5, note_seg6, octave_state}, 0);
    chk("reset flags", {frame_valid, pattern_error, select_error, scan_timeout}, 0);

    for (int i = 0; i < 6; i++) begin
      scan_frame(vec[i]);
      check_frame($sformatf("vec%0d", i), vec[i]);
    end

    // Stable non-one-hot select: sticky error, nothing captured or published.
    pulse_clr();
    chk("select_error before", select_error, 1'b0);
    fv_cnt = 0;
    drive(8'h05, N1);
    repeat (10) tick();
    drive(8'h00, BL);
    repeat (4) tick();
    chk("select_error set", select_error, 1'b1);
    chk("select no frame", fv_cnt, 0);
    chk("select notes held", {note_seg1, note_seg2, note_seg3, note_seg4, note_seg5, note_seg6},
        vec[5].notes);
    pulse_clr();
    chk("select_error cleared", select_error, 1'b0);

    // Partial frame then idle: timeout after 200 idle cycles discards seen slots.
    for (int k = 0; k < 4; k++) scan_slot(k, vec[0].pat[k], 10);
    drive(8'h00, BL);
    repeat (150) tick();
    chk("timeout early", scan_timeout, 1'b0);
    repeat (100) tick();
    chk("timeout set", scan_timeout, 1'b1);
    chk("timeout outputs kept", octave_state, vec[5].oct);
    fv_cnt = 0;
    scan_slot(4, vec[2].pat[4], 10);
    chk("timeout cleared by capture", scan_timeout, 1'b0);
    for (int k = 5; k < 8; k++) scan_slot(k, vec[2].pat[k], 10);
    for (int k = 0; k < 3; k++) scan_slot(k, vec[2].pat[k], 10);
    chk("rescan no early frame", fv_cnt, 0);
    // Minimum 4-cycle dwell on the last slot; frame_valid lands 7 samples after the change.
    drive(8'b1 << 3, vec[2].pat[3]);
    fv_tick = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (frame_valid === 1'b1 && fv_tick == 0) fv_tick = i;
      if (i == 4) drive(8'h00, BL);
    end
    chk("last slot latency", fv_tick, 7);
    chk("rescan frame_valid pulses", fv_cnt, 1);
    chk("rescan suffix", suffix_code, vec[2].suf);
    chk("rescan notes", {note_seg1, note_seg2, note_seg3, note_seg4, note_seg5, note_seg6},
        vec[2].notes);
    chk("rescan octave", octave_state, vec[2].oct);

    // Reset mid-frame discards pending slots.
    for (int k = 0; k < 7; k++) scan_slot(k, vec[0].pat[k], 10);
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    fv_cnt = 0;
    scan_slot(7, vec[0].pat[7], 10);
    drive(8'h00, BL);
    repeat (6) tick();
    chk("post-reset no frame", fv_cnt, 0);
    chk("post-reset outputs", {suffix_code, note_seg1, note_seg2, note_seg3, note_seg4,
                               note_seg5, note_seg6, octave_state}, 0);
    chk("post-reset flags", {pattern_error, select_error, scan_timeout}, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
